// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the fifo_flow slice.
//   DEF_DATA_WIDTH / DEF_DEPTH : default word width and entry count.
//   clog2_f                    : ceiling log2, used to derive pointer widths.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_DEPTH      = 8;

  // Smallest r such that 2**r >= value (value >= 1).
  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage, one synchronous write port and one
// synchronous read port, no reset on the array or the read register.
//   clk     : clock, rising edge
//   wr_en   : write strobe; wr_data stored at wr_addr
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe; mem[rd_addr] captured into rd_data
//   rd_addr : read address
//   rd_data : registered read data, holds when rd_en=0
// A read and write to the same address in one cycle returns the old word.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2_f(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output, holds its value between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_flow.sv
// fifo_flow: synchronous FIFO with level reporting, almost-full/empty flags,
// hysteretic pause back-pressure and a sticky overflow/underflow error.
//   clk          : clock, rising edge
//   RESET_L      : asynchronous active-low reset
//   data_in      : write data            fifo_wr / fifo_rd : requests
//   al_full_in   : almost-full / pause-assert threshold
//   al_empty_in  : almost-empty / pause-release threshold
//   err_clr      : clears err_fifo (a coincident new error wins)
//   data_out     : read data, 1-cycle latency, holds between reads
//   valid_out    : data_out carries a word read on the previous edge
//   fifo_empty / fifo_full / almost_full / almost_empty / level : occupancy
//   pause        : registered hysteretic back-pressure
//   err_fifo     : sticky error flag
module fifo_flow
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2_f(DEPTH)
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic [ADDR_WIDTH:0]   al_full_in,
  input  logic [ADDR_WIDTH:0]   al_empty_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  pause,
  output logic                  err_fifo,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int                    LVL_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LVL_WIDTH-1:0]  LVL_FULL  = LVL_WIDTH'(DEPTH);
  localparam logic [LVL_WIDTH-1:0]  LVL_ZERO  = {LVL_WIDTH{1'b0}};
  localparam logic [LVL_WIDTH-1:0]  LVL_ONE   = {{(LVL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [LVL_WIDTH-1:0]  level_r;
  logic [LVL_WIDTH-1:0]  level_nxt_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  err_s;
  logic                  valid_r;
  logic                  pause_r;
  logic                  err_r;
  logic                  rd_seen_r;
  logic [DATA_WIDTH-1:0] ram_q_s;

  // Accept/reject decisions; a full FIFO still takes a write when a read frees a slot.
  always_comb begin
    rd_acc_s = fifo_rd & (level_r != LVL_ZERO);
    wr_acc_s = fifo_wr & ((level_r != LVL_FULL) | rd_acc_s);
    err_s    = (fifo_wr & ~wr_acc_s) | (fifo_rd & ~rd_acc_s);
  end

  // Next occupancy from the accepted operations.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers, level, valid, pause and error state.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      level_r   <= LVL_ZERO;
      valid_r   <= 1'b0;
      pause_r   <= 1'b0;
      err_r     <= 1'b0;
      rd_seen_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_seen_r <= 1'b1;
      end
      level_r <= level_nxt_s;
      valid_r <= rd_acc_s;
      // Release is checked first so it wins when the thresholds overlap.
      if (level_nxt_s <= al_empty_in) begin
        pause_r <= 1'b0;
      end else if (level_nxt_s >= al_full_in) begin
        pause_r <= 1'b1;
      end
      if (err_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_q_s)
  );

  // The RAM read register has no reset; rd_seen_r masks it to zero until the
  // first read after reset so data_out shows its reset value immediately.
  assign data_out     = rd_seen_r ? ram_q_s : {DATA_WIDTH{1'b0}};
  assign valid_out    = valid_r;
  assign pause        = pause_r;
  assign err_fifo     = err_r;
  assign level        = level_r;
  assign fifo_empty   = (level_r == LVL_ZERO);
  assign fifo_full    = (level_r == LVL_FULL);
  assign almost_full  = (level_r >= al_full_in);
  assign almost_empty = (level_r <= al_empty_in);

endmodule

// File: tb/tb_fifo_flow.sv
// tb_fifo_flow: table-driven directed check of fifo_flow (DATA_WIDTH=6,
// DEPTH=8), plus hand-written sequences for reset behaviour.
module tb_fifo_flow;

  logic       clk;
  logic       RESET_L;
  logic [5:0] data_in;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [3:0] al_full_in;
  logic [3:0] al_empty_in;
  logic       err_clr;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       pause;
  logic       err_fifo;
  logic [3:0] level;

  int checks;
  int failures;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [5:0] din;
    logic [3:0] af;
    logic [3:0] ae;
    logic       clr;
    logic [3:0] lvl;
    logic       vld;
    logic [5:0] dout;
    logic       pse;
    logic       err;
  } vec_t;

  vec_t vq[$];

  fifo_flow #(
    .DATA_WIDTH (6),
    .DEPTH      (8)
  ) dut (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .data_in      (data_in),
    .fifo_wr      (fifo_wr),
    .fifo_rd      (fifo_rd),
    .al_full_in   (al_full_in),
    .al_empty_in  (al_empty_in),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .err_fifo     (err_fifo),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [5:0] din,
                     input logic [3:0] af, input logic [3:0] ae, input logic clr,
                     input logic [3:0] lvl, input logic vld, input logic [5:0] dout,
                     input logic pse, input logic err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.af = af; v.ae = ae; v.clr = clr;
    v.lvl = lvl; v.vld = vld; v.dout = dout; v.pse = pse; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check_row(input int idx, input vec_t v);
    check($sformatf("row%0d level", idx),        32'(level),        32'(v.lvl));
    check($sformatf("row%0d valid_out", idx),    32'(valid_out),    32'(v.vld));
    check($sformatf("row%0d data_out", idx),     32'(data_out),     32'(v.dout));
    check($sformatf("row%0d pause", idx),        32'(pause),        32'(v.pse));
    check($sformatf("row%0d err_fifo", idx),     32'(err_fifo),     32'(v.err));
    check($sformatf("row%0d fifo_full", idx),    32'(fifo_full),    32'(v.lvl == 4'd8));
    check($sformatf("row%0d fifo_empty", idx),   32'(fifo_empty),   32'(v.lvl == 4'd0));
    check($sformatf("row%0d almost_full", idx),  32'(almost_full),  32'(v.lvl >= v.af));
    check($sformatf("row%0d almost_empty", idx), 32'(almost_empty), 32'(v.lvl <= v.ae));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " level"},        32'(level),        32'd0);
    check({tag, " data_out"},     32'(data_out),     32'd0);
    check({tag, " valid_out"},    32'(valid_out),    32'd0);
    check({tag, " pause"},        32'(pause),        32'd0);
    check({tag, " err_fifo"},     32'(err_fifo),     32'd0);
    check({tag, " fifo_empty"},   32'(fifo_empty),   32'd1);
    check({tag, " fifo_full"},    32'(fifo_full),    32'd0);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Ordered fill then drain of 0x01..0x08; pause sets at level 6, releases at 2.
    for (int i = 1; i <= 8; i++)
      add(1'b1, 1'b0, 6'(i), 4'd6, 4'd2, 1'b0, 4'(i), 1'b0, 6'h00, (i >= 6), 1'b0);
    for (int i = 1; i <= 8; i++)
      add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b0, 4'(8 - i), 1'b1, 6'(i), ((8 - i) > 2), 1'b0);
    // Refill with 0x21..0x28.
    for (int i = 1; i <= 8; i++)
      add(1'b1, 1'b0, 6'(32 + i), 4'd6, 4'd2, 1'b0, 4'(i), 1'b0, 6'h08, (i >= 6), 1'b0);
    // Overflow of 0x3F, then clear.
    add(1'b1, 1'b0, 6'h3F, 4'd6, 4'd2, 1'b0, 4'd8, 1'b0, 6'h08, 1'b1, 1'b1);
    add(1'b0, 1'b0, 6'h00, 4'd6, 4'd2, 1'b1, 4'd8, 1'b0, 6'h08, 1'b1, 1'b0);
    // Full with simultaneous read/write: level holds, oldest words out.
    for (int i = 1; i <= 4; i++)
      add(1'b1, 1'b1, 6'(16 + i), 4'd6, 4'd2, 1'b0, 4'd8, 1'b1, 6'(32 + i), 1'b1, 1'b0);
    // Drain: 0x25..0x28 then 0x11..0x14, never 0x3F.
    for (int i = 1; i <= 4; i++)
      add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b0, 4'(8 - i), 1'b1, 6'(36 + i), 1'b1, 1'b0);
    for (int i = 5; i <= 8; i++)
      add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b0, 4'(8 - i), 1'b1, 6'(12 + i), ((8 - i) > 2), 1'b0);
    // Idle: data_out holds, valid drops.
    add(1'b0, 1'b0, 6'h00, 4'd6, 4'd2, 1'b0, 4'd0, 1'b0, 6'h14, 1'b0, 1'b0);
    // Underflow, clear, then rd+wr on empty (write only, read rejected).
    add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b0, 4'd0, 1'b0, 6'h14, 1'b0, 1'b1);
    add(1'b0, 1'b0, 6'h00, 4'd6, 4'd2, 1'b1, 4'd0, 1'b0, 6'h14, 1'b0, 1'b0);
    add(1'b1, 1'b1, 6'h2A, 4'd6, 4'd2, 1'b0, 4'd1, 1'b0, 6'h14, 1'b0, 1'b1);
    add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b0, 4'd0, 1'b1, 6'h2A, 1'b0, 1'b1);
    // Clear coinciding with a new underflow: error wins; then a plain clear.
    add(1'b0, 1'b1, 6'h00, 4'd6, 4'd2, 1'b1, 4'd0, 1'b0, 6'h2A, 1'b0, 1'b1);
    add(1'b0, 1'b0, 6'h00, 4'd6, 4'd2, 1'b1, 4'd0, 1'b0, 6'h2A, 1'b0, 1'b0);
    // Threshold above DEPTH: pause and almost_full never assert.
    for (int i = 1; i <= 8; i++)
      add(1'b1, 1'b0, 6'(48 + i), 4'd9, 4'd0, 1'b0, 4'(i), 1'b0, 6'h2A, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++)
      add(1'b0, 1'b1, 6'h00, 4'd9, 4'd0, 1'b0, 4'(8 - i), 1'b1, 6'(48 + i), 1'b0, 1'b0);
    // Underflow, then fill to 5 with pause threshold 4 ahead of the reset test.
    add(1'b0, 1'b1, 6'h00, 4'd4, 4'd1, 1'b0, 4'd0, 1'b0, 6'h38, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++)
      add(1'b1, 1'b0, 6'(10 + i), 4'd4, 4'd1, 1'b0, 4'(i), 1'b0, 6'h38, (i >= 4), 1'b1);

    // Power-on reset.
    RESET_L     = 1'b0;
    data_in     = 6'h00;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    al_full_in  = 4'd6;
    al_empty_in = 4'd2;
    err_clr     = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    RESET_L = 1'b1;

    foreach (vq[i]) begin
      data_in     = vq[i].din;
      fifo_wr     = vq[i].wr;
      fifo_rd     = vq[i].rd;
      al_full_in  = vq[i].af;
      al_empty_in = vq[i].ae;
      err_clr     = vq[i].clr;
      @(posedge clk);
      #1;
      check_row(i, vq[i]);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle with level 5: outputs clear before the next edge.
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    #2;
    RESET_L = 1'b0;
    #1;
    check_reset_state("async");
    @(negedge clk);
    RESET_L = 1'b1;
    // First read after release must see an empty FIFO.
    fifo_rd = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset read err_fifo",  32'(err_fifo),  32'd1);
    check("post-reset read valid_out", 32'(valid_out), 32'd0);
    check("post-reset read level",     32'(level),     32'd0);
    check("post-reset read data_out",  32'(data_out),  32'd0);
    @(negedge clk);
    fifo_rd = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
